// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, mult/div and slow-memory waits.
// Outputs are combinational from state/cnt/inputs; optional stall counter under HAZARD_STALL_CNT_EN.
module pipe_hazard_sequencer #(
  parameter int MEM_LAT = 2,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_MulDiv,
  input  logic        EX_BranchTaken,
  input  logic        MEM_Access,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_flush,
  output logic        exmem_write,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        hazard_detected,
  output logic        busy,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MD_BUSY} state_t;

  localparam logic [CNT_W-1:0] MEM_INIT = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] MD_INIT  = (MD_LAT > 1)  ? CNT_W'(MD_LAT - 2)  : '0;
  localparam logic             MEM_SLOW = (MEM_LAT > 1);
  localparam logic             MD_SLOW  = (MD_LAT > 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_load_use;
  logic             w_mask_mem, w_mask_md, w_release;

  assign w_load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_write      = 1'b1;
    idex_flush      = 1'b0;
    exmem_write     = 1'b1;
    exmem_flush     = 1'b0;
    memwb_flush     = 1'b0;
    hazard_detected = 1'b0;
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mask_mem      = 1'b0;
    w_mask_md       = 1'b0;
    w_release       = 1'b0;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        MEM_WAIT: begin
          w_release  = (r_cnt == '0);
          w_mask_mem = 1'b1;
        end
        MD_BUSY: begin
          w_release = (r_cnt == '0);
          w_mask_md = 1'b1;
        end
        default: w_release = 1'b1;
      endcase

      if (!w_release) begin
        // Still waiting: keep applying the hold that started this wait.
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_state == MEM_WAIT) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
        end
      end else if (MEM_Access && MEM_SLOW && !w_mask_mem) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_flush = 1'b1;
        w_cnt_nxt   = MEM_INIT;
        w_state_nxt = MEM_WAIT;
      end else if (EX_MulDiv && MD_SLOW && !w_mask_md) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_flush = 1'b1;
        w_cnt_nxt   = MD_INIT;
        w_state_nxt = MD_BUSY;
      end else begin
        w_state_nxt = RUN;
        if (EX_BranchTaken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_load_use) begin
          pc_write        = 1'b0;
          ifid_write      = 1'b0;
          idex_flush      = 1'b1;
          hazard_detected = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
    r_cnt   <= w_cnt_nxt;
  end

  assign busy = !rst && (r_state != RUN);

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!pc_write && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_sequencer.md
Name: pipe_hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives write-enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and drives hazard_detected into Control.
- Sequences four events:
  - load-use stalls
  - taken-branch flushes
  - multi-cycle mult/div occupancy in EX
  - multi-cycle data-memory accesses in MEM.

Parameters:
- MEM_LAT, 2, data-memory access latency in cycles (1 = single-cycle, never freezes; legal 1..2^CNT_W).
- MD_LAT, 4, mult/div latency in cycles (1 = never stalls; legal 1..2^CNT_W).
- CNT_W, 4, width of the shared wait counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- ID_UsesRt  in  1  ID instruction reads rt as a source
- EX_MemRead  in  1  instruction in EX is a load
- EX_Rt  in  5  destination rt of EX load
- EX_MulDiv  in  1  instruction in EX is mult/div
- EX_BranchTaken  in  1  branch resolved taken in EX
- MEM_Access  in  1  instruction in MEM is a load/store
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_write  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX load bubble
- exmem_write  out  1  EX/MEM load enable
- exmem_flush  out  1  EX/MEM load bubble
- memwb_flush  out  1  MEM/WB load bubble
- hazard_detected  out  1  to Control: zero control fields
- busy  out  1  state != RUN
- stall_count  out  32  stalled-cycle counter (see Optional Feature)

Behaviour:
- State register: RUN, MEM_WAIT, MD_BUSY. Counter cnt is CNT_W bits. Outputs are combinational from state, cnt and inputs.
- Default action (NORMAL): all *_write=1, all flushes=0, hazard_detected=0.
- Reset:
  - While rst=1, all *_write=0, all flushes=0, hazard_detected=0, busy=0.
  - Next state is RUN and cnt is 0.
  - A reset mid-wait aborts the wait immediately.
- Actions:
  - FREEZE_ALL: pc_write=ifid_write=idex_write=exmem_write=0, memwb_flush=1.
  - MD_HOLD: pc_write=ifid_write=idex_write=0, exmem_flush=1, exmem_write=1.
  - BR_FLUSH: ifid_flush=1, idex_flush=1, writes=1.
  - LOAD_USE: pc_write=ifid_write=0, idex_flush=1, hazard_detected=1.
- RUN evaluates triggers in priority order; first match wins:
  1. MEM_Access && MEM_LAT>1 -> FREEZE_ALL, cnt<=MEM_LAT-2, go MEM_WAIT.
  2. EX_MulDiv && MD_LAT>1 -> MD_HOLD, cnt<=MD_LAT-2, go MD_BUSY.
  3. EX_BranchTaken -> BR_FLUSH. Overrides load-use.
  4. EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UsesRt && EX_Rt==ID_Rt)) -> LOAD_USE. Lasts one cycle because EX then holds a bubble.
  5. Otherwise NORMAL.
- MEM_WAIT:
  - cnt!=0 -> FREEZE_ALL, cnt--.
  - cnt==0 is the release cycle: apply RUN rules 2-5 with rule 1 masked, and take their state transition. No retrigger on the still-asserted MEM_Access.
- MD_BUSY:
  - cnt!=0 -> MD_HOLD, cnt--.
  - cnt==0 is the release cycle: apply RUN rules 1,3,4,5 with rule 2 masked.
- Total frozen cycles per event = LAT-1, then exactly one release cycle.
- Back-to-back accesses: a new MEM_Access on the cycle after release starts a new wait.
- busy=1 whenever state is MEM_WAIT or MD_BUSY, including the release cycle.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined: stall_count resets to 0 and increments on every non-reset cycle with pc_write==0. It saturates at 32'hFFFFFFFF.
- Undefined: stall_count is constant 0 and no counter logic is built.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1, hazard_detected=1. With EX_Rt=0 -> NORMAL.
- Branch over load-use: EX_BranchTaken=1 with the load-use condition true -> ifid_flush=idex_flush=1, pc_write=1, hazard_detected=0.
- MD_LAT=4: EX_MulDiv held high -> 3 cycles MD_HOLD (exmem_flush=1), 4th cycle NORMAL, then RUN.
- MEM_LAT=3: MEM_Access and EX_MulDiv both high (MD_LAT=4) -> 2 cycles FREEZE_ALL, release cycle shows MD_HOLD, then 2 more MD_HOLD, then release.
- Reset mid-wait: rst=1 on the 2nd MD_BUSY cycle -> next cycle state RUN, busy=0, outputs NORMAL.
- HAZARD_STALL_CNT_EN defined with the MEM_LAT=3 scenario above -> stall_count=5. Undefined -> stall_count=0.
